sd_spi_host: RTL and testbench
==============================

# sd_spi_host

SPI-mode SD host engine for the bridge: converts one single-block read or write request into an SD command frame on MOSI and serialises or deserialises a 64-bit data block with CRC16 over MISO. It is the initiator for the SD card model. It sits between the bridge's request/response handshake and the card pins, with no buffering beyond one block. One transaction is in flight at a time.

## Interface
- `UNIT`, 8: cycles per byte slot; write-token gap and timeout granularity.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request strobe, accepted only in IDLE.
- `direction`  in  1  0 = read (CMD17), 1 = write (CMD24).
- `addr`  in  16  block address; zero-extended to the 32-bit argument.
- `data_in`  in  64  write payload, captured with the request.
- `MISO`  in  1  card-to-host serial line.
- `MOSI`  out  1  host-to-card serial line, registered.
- `busy`  out  1  high from acceptance until the `out_valid` cycle inclusive.
- `out_valid`  out  1  one-cycle completion pulse.
- `data_out`  out  64  read block; valid only while `out_valid` is high, 0 otherwise.
- `err`  out  1  qualified by `out_valid`: CRC16 mismatch, bad data response, or timeout.

## Operation
- Frame: 48 bits sent MSB first: `0`, `1`, cmd[5:0], arg[31:0], crc7[6:0], `1`.
  - crc7 uses polynomial x^7+x^3+1 (0x09), init 0, over the first 40 bits.
- CRC16: polynomial 0x1021, init 0, over the 64 data bits MSB first, computed serially bit by bit.
- States and transitions:
  - IDLE → CMD on `in_valid`.
  - CMD sends 48 bits → WAIT_R1.
  - WAIT_R1 waits for MISO==0; that cycle is R1 bit 0. R1 lasts 8 cycles and its value is not checked.
  - Read: → WAIT_TOK. The first MISO==0 ends the 0xFE token. → RD_DATA (64 bits) → RD_CRC (16 bits) → DONE.
    - `err` = received CRC != computed CRC.
  - Write: → WR_GAP drives MOSI=1 for exactly UNIT cycles. → WR_TOK sends 8'hFE. → WR_DATA (64 bits) → WR_CRC (16 bits) → WAIT_DR.
    - WAIT_DR waits for MISO==0 and captures 8 bits.
    - `err` = captured[4:0] != 5'b00101.
    - → WAIT_BUSY until MISO==1 → DONE.
- DONE: one cycle with `out_valid`=1, then → IDLE.
- MOSI is 1 in every state that is not actively transmitting.
- `in_valid` while `busy` is ignored; no queueing.
- `addr` and `data_in` are registered at acceptance; later input changes have no effect.

## Timing
- Reset values: MOSI=1, busy=0, out_valid=0, data_out=0, err=0, state IDLE.
- Reset mid-transaction aborts immediately next cycle with no `out_valid`.
- Command start bit (0) appears on MOSI the cycle after `in_valid` is sampled.
- MISO is sampled on the rising edge; a bit received in cycle n is usable in cycle n+1.
- Write token last bit (0) is driven exactly UNIT+8 cycles after the last R1 bit.
- First data bit follows the token with no gap.
- Read `out_valid` occurs 1 cycle after the last CRC bit is sampled.
- Write `out_valid` occurs 1 cycle after MISO is first sampled high in WAIT_BUSY.
- Zero-length busy (MISO high immediately after data response) is legal.

## Configuration
- `SD_HOST_TIMEOUT_EN` defined:
  - A 10-bit watchdog runs in WAIT_R1, WAIT_TOK, WAIT_DR and WAIT_BUSY, and clears on every state change.
  - Reaching 64*UNIT cycles forces DONE with `err`=1 and `data_out`=0.
- Undefined: wait states wait indefinitely. The watchdog logic is absent.

## Test plan
- Read addr 16'h0000, card returns 64'h0123_4567_89AB_CDEF with correct CRC16 → MOSI frame 48'h51_0000_0000_55; `out_valid` with data_out=64'h0123456789ABCDEF, err=0.
- Write addr 16'h0010, data_in=64'h0:
  - MOSI shows 8 ones, then 0xFE, 64 zeros, CRC 16'h0000.
  - Card returns 8'b0000_0101, then 40 busy cycles.
  - → `out_valid`, err=0, exactly 1 cycle after MISO rises.
- Read with corrupted CRC (bit 15 flipped) → `out_valid`, err=1, data_out still holds the received block.
- Write with data response 8'b0000_1011 → err=1 after busy release.
- `in_valid` pulsed mid-read with different addr → ignored; the second frame is never emitted.
- Assert `rst` during WR_DATA → MOSI=1 and busy=0 next cycle.
- With `SD_HOST_TIMEOUT_EN`, MISO held at 1 after CMD17 → err=1 and `out_valid` 512 cycles after entering WAIT_R1.

Source files
------------

// File: rtl/sd_spi_host_if.sv
// Bridge-side request/response handshake of the SD SPI host engine.
// The bridge drives the master modport; sd_spi_host uses the slave modport.
interface sd_spi_host_if;
    logic        in_valid;
    logic        direction;
    logic [15:0] addr;
    logic [63:0] data_in;
    logic        busy;
    logic        out_valid;
    logic [63:0] data_out;
    logic        err;

    modport master (
        output in_valid, direction, addr, data_in,
        input  busy, out_valid, data_out, err
    );

    modport slave (
        input  in_valid, direction, addr, data_in,
        output busy, out_valid, data_out, err
    );
endinterface

// File: rtl/sd_spi_host.sv
// SPI-mode SD host: single-block CMD17 read / CMD24 write with serial CRC16.
// Optional watchdog on the card wait states is enabled by defining SD_HOST_TIMEOUT_EN.
module sd_spi_host #(
    parameter int UNIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    sd_spi_host_if.slave bus,
    input  logic         MISO,
    output logic         MOSI
);
    typedef enum logic [3:0] {
        IDLE, CMD, WAIT_R1, R1_BITS, WAIT_TOK, RD_DATA, RD_CRC,
        WR_GAP, WR_TOK, WR_DATA, WR_CRC, WAIT_DR, DR_BITS, WAIT_BUSY, DONE
    } state_t;

    localparam logic [7:0] TOKEN    = 8'hFE;
    localparam logic [7:0] GAP_LAST = 8'(UNIT - 1);

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        // NOTE: blocking assignments are correct here; function locals are combinational temporaries.
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    function automatic logic [47:0] make_frame(input logic wr, input logic [15:0] a);
        logic [39:0] head;
        logic [6:0]  crc;
        logic        fb;
        head = {2'b01, (wr ? 6'd24 : 6'd17), 16'h0000, a};
        crc  = '0;
        for (int i = 39; i >= 0; i--) begin
            fb  = crc[6] ^ head[i];
            crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return {head, crc, 1'b1};
    endfunction

    state_t      state;
    logic [7:0]  cnt;
    logic        dir_q;
    logic [47:0] cmd_sr;
    logic [63:0] data_sr;
    logic [15:0] crc;
    logic [14:0] rx_sr;
    logic        resp_bad;
    logic        busy_q;
    logic        out_valid_q;
    logic [63:0] data_out_q;
    logic        err_q;
    logic [47:0] frame;
    logic        timeout;

    assign frame         = make_frame(bus.direction, bus.addr);
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.err       = err_q;

`ifdef SD_HOST_TIMEOUT_EN
    localparam logic [9:0] WDOG_LAST = 10'(64 * UNIT - 1);
    logic [9:0] wdog;
    logic       in_wait;

    // Wait states only ever exit to non-wait states, so clearing outside them clears on every change.
    assign in_wait = (state == WAIT_R1) || (state == WAIT_TOK) ||
                     (state == WAIT_DR) || (state == WAIT_BUSY);
    assign timeout = in_wait && (wdog == WDOG_LAST);

    always_ff @(posedge clk) begin
        if (rst || !in_wait) wdog <= '0;
        else                 wdog <= wdog + 10'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            MOSI        <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            err_q       <= 1'b0;
            cnt         <= '0;
            dir_q       <= 1'b0;
            cmd_sr      <= '0;
            data_sr     <= '0;
            crc         <= '0;
            rx_sr       <= '0;
            resp_bad    <= 1'b0;
        end else if (timeout) begin
            state       <= DONE;
            MOSI        <= 1'b1;
            out_valid_q <= 1'b1;
            err_q       <= 1'b1;
            data_out_q  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    state   <= CMD;
                    busy_q  <= 1'b1;
                    dir_q   <= bus.direction;
                    data_sr <= bus.data_in;
                    crc     <= '0;
                    cnt     <= '0;
                    MOSI    <= frame[47];
                    cmd_sr  <= {frame[46:0], 1'b1};
                end
                CMD: if (cnt == 8'd47) begin
                    MOSI  <= 1'b1;
                    cnt   <= '0;
                    state <= WAIT_R1;
                end else begin
                    MOSI   <= cmd_sr[47];
                    cmd_sr <= {cmd_sr[46:0], 1'b1};
                    cnt    <= cnt + 8'd1;
                end
                WAIT_R1: if (!MISO) begin
                    cnt   <= 8'd1;
                    state <= R1_BITS;
                end
                R1_BITS: if (cnt == 8'd7) begin
                    cnt   <= '0;
                    state <= dir_q ? WR_GAP : WAIT_TOK;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                WAIT_TOK: if (!MISO) begin
                    cnt   <= '0;
                    state <= RD_DATA;
                end
                RD_DATA: begin
                    data_sr <= {data_sr[62:0], MISO};
                    crc     <= crc16_step(crc, MISO);
                    if (cnt == 8'd63) begin
                        cnt   <= '0;
                        state <= RD_CRC;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RD_CRC: begin
                    rx_sr <= {rx_sr[13:0], MISO};
                    if (cnt == 8'd15) begin
                        out_valid_q <= 1'b1;
                        err_q       <= ({rx_sr, MISO} != crc);
                        data_out_q  <= data_sr;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WR_GAP: if (cnt == GAP_LAST) begin
                    MOSI   <= TOKEN[7];
                    cmd_sr <= {TOKEN[6:0], {41{1'b1}}};
                    cnt    <= '0;
                    state  <= WR_TOK;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                // Each data bit enters the CRC on the edge that puts it on MOSI.
                WR_TOK: if (cnt == 8'd7) begin
                    MOSI    <= data_sr[63];
                    crc     <= crc16_step(crc, data_sr[63]);
                    data_sr <= {data_sr[62:0], 1'b0};
                    cnt     <= 8'd1;
                    state   <= WR_DATA;
                end else begin
                    MOSI   <= cmd_sr[47];
                    cmd_sr <= {cmd_sr[46:0], 1'b1};
                    cnt    <= cnt + 8'd1;
                end
                WR_DATA: if (cnt == 8'd64) begin
                    MOSI  <= crc[15];
                    crc   <= {crc[14:0], 1'b0};
                    cnt   <= 8'd1;
                    state <= WR_CRC;
                end else begin
                    MOSI    <= data_sr[63];
                    crc     <= crc16_step(crc, data_sr[63]);
                    data_sr <= {data_sr[62:0], 1'b0};
                    cnt     <= cnt + 8'd1;
                end
                WR_CRC: if (cnt == 8'd16) begin
                    MOSI  <= 1'b1;
                    cnt   <= '0;
                    state <= WAIT_DR;
                end else begin
                    MOSI <= crc[15];
                    crc  <= {crc[14:0], 1'b0};
                    cnt  <= cnt + 8'd1;
                end
                WAIT_DR: if (!MISO) begin
                    rx_sr <= '0;
                    cnt   <= 8'd1;
                    state <= DR_BITS;
                end
                DR_BITS: begin
                    rx_sr <= {rx_sr[13:0], MISO};
                    if (cnt == 8'd7) begin
                        resp_bad <= ({rx_sr[3:0], MISO} != 5'b00101);
                        cnt      <= '0;
                        state    <= WAIT_BUSY;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WAIT_BUSY: if (MISO) begin
                    out_valid_q <= 1'b1;
                    err_q       <= resp_bad;
                    data_out_q  <= '0;
                    state       <= DONE;
                end
                DONE: begin
                    out_valid_q <= 1'b0;
                    err_q       <= 1'b0;
                    data_out_q  <= '0;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_spi_host.sv
// Self-checking bench for sd_spi_host: scheduled card model on MISO, cycle-indexed MOSI capture,
// CRCs computed by polynomial long division. Define SD_HOST_TIMEOUT_EN to cover the watchdog.
`timescale 1ns/1ps
module tb_sd_spi_host;
    localparam int UNIT = 8;
    localparam int MAXC = 4096;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic MISO = 1'b1;
    logic MOSI;

    sd_spi_host_if bus();

    sd_spi_host #(.UNIT(UNIT)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .MISO (MISO),
        .MOSI (MOSI)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic        miso_sched [MAXC];
    logic        mosi_rec   [MAXC];
    int          ov_cycle, ov_count, last_cycle;
    logic [63:0] ov_data, post_data;
    logic        ov_err, post_busy, post_ov, busy1;
    logic        rst_mosi, rst_busy, rst_ov;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] m_crc7(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'd0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [15:0] m_crc16(input logic [63:0] d);
        logic [79:0] r;
        r = {d, 16'd0};
        for (int i = 79; i >= 16; i--)
            if (r[i]) r[i -: 17] = r[i -: 17] ^ 17'h11021;
        return r[15:0];
    endfunction

    function automatic logic [47:0] m_frame(input logic wr, input logic [15:0] a);
        logic [39:0] head;
        head = {2'b01, (wr ? 6'd24 : 6'd17), 16'h0000, a};
        return {head, m_crc7(head), 1'b1};
    endfunction

    task automatic sched_clear();
        for (int i = 0; i < MAXC; i++) miso_sched[i] = 1'b1;
    endtask

    task automatic sched_put(input int start, input logic [63:0] v, input int n);
        for (int k = 0; k < n; k++) miso_sched[start + k] = v[n - 1 - k];
    endtask

    function automatic logic [63:0] rec_bits(input int start, input int n);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v = {v[62:0], mosi_rec[start + k]};
        return v;
    endfunction

    function automatic int rec_zeros(input int from, input int to);
        int n;
        n = 0;
        for (int i = from; i <= to; i++) if (mosi_rec[i] == 1'b0) n++;
        return n;
    endfunction

    // Cycle j is the j-th clock period after the posedge that samples in_valid.
    task automatic run_txn(input logic dir, input logic [15:0] a, input logic [63:0] d,
                           input int inject_at, input int rst_at, input int max_cyc, input int tail);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.direction = dir;
        bus.addr      = a;
        bus.data_in   = d;
        MISO          = 1'b1;
        ov_cycle   = -1;
        ov_count   = 0;
        last_cycle = max_cyc;
        for (int i = 0; i < MAXC; i++) mosi_rec[i] = 1'b1;
        for (int j = 1; j <= max_cyc; j++) begin
            @(negedge clk);
            bus.in_valid  = (j == inject_at);
            bus.direction = (j == inject_at) ? ~dir : 1'($urandom);
            bus.addr      = (j == inject_at) ? ~a : 16'($urandom);
            bus.data_in   = {$urandom, $urandom};
            mosi_rec[j] = MOSI;
            if (j == 1) busy1 = bus.busy;
            if (rst_at > 0 && j == rst_at + 1) begin
                rst_mosi = MOSI;
                rst_busy = bus.busy;
                rst_ov   = bus.out_valid;
                rst      = 1'b0;
            end
            if (rst_at > 0 && j == rst_at) rst = 1'b1;
            if (bus.out_valid) begin
                ov_count++;
                if (ov_cycle < 0) begin
                    ov_cycle = j;
                    ov_data  = bus.data_out;
                    ov_err   = bus.err;
                end
            end
            if (ov_cycle > 0 && j == ov_cycle + 1) begin
                post_busy = bus.busy;
                post_ov   = bus.out_valid;
                post_data = bus.data_out;
            end
            MISO = miso_sched[j];
            if (ov_cycle > 0 && j >= ov_cycle + tail) begin
                last_cycle = j;
                break;
            end
        end
    endtask

    task automatic chk_read(input string tag, input logic [15:0] a, input logic [63:0] blk,
                            input logic [15:0] flip, input int d1, input int d2, input int inject_at);
        int r1, tok, last;
        sched_clear();
        r1  = 49 + d1;
        sched_put(r1, 64'h00, 8);
        tok = r1 + 8 + d2;
        sched_put(tok, 64'hFE, 8);
        sched_put(tok + 8, blk, 64);
        sched_put(tok + 72, 64'(m_crc16(blk) ^ flip), 16);
        last = tok + 87;
        run_txn(1'b0, a, {$urandom, $urandom}, inject_at, 0, last + 200, 40);
        check({tag, " frame"}, rec_bits(1, 48), 64'(m_frame(1'b0, a)));
        check({tag, " busy_start"}, 64'(busy1), 64'd1);
        check({tag, " ov_cycle"}, 64'(ov_cycle), 64'(last + 1));
        check({tag, " ov_count"}, 64'(ov_count), 64'd1);
        check({tag, " err"}, 64'(ov_err), 64'(flip != 16'h0));
        check({tag, " data_out"}, ov_data, blk);
        check({tag, " post_busy"}, 64'(post_busy), 64'd0);
        check({tag, " post_ov"}, 64'(post_ov), 64'd0);
        check({tag, " post_data"}, post_data, 64'd0);
        check({tag, " mosi_idle"}, 64'(rec_zeros(49, last_cycle)), 64'd0);
    endtask

    task automatic chk_write(input string tag, input logic [15:0] a, input logic [63:0] d,
                             input logic [7:0] resp, input int d1, input int d2, input int nb);
        int lr, s, r;
        sched_clear();
        lr = 56 + d1;
        sched_put(lr - 7, 64'h00, 8);
        s = lr + 97 + d2;
        sched_put(s, 64'(resp), 8);
        sched_put(s + 8, 64'h0, nb);
        r = s + 8 + nb;
        run_txn(1'b1, a, d, 0, 0, r + 200, 20);
        check({tag, " frame"}, rec_bits(1, 48), 64'(m_frame(1'b1, a)));
        check({tag, " busy_start"}, 64'(busy1), 64'd1);
        check({tag, " gap_ones"}, 64'(rec_zeros(49, lr + 8)), 64'd0);
        check({tag, " token"}, rec_bits(lr + 9, 8), 64'hFE);
        check({tag, " wr_data"}, rec_bits(lr + 17, 64), d);
        check({tag, " wr_crc"}, rec_bits(lr + 81, 16), 64'(m_crc16(d)));
        check({tag, " mosi_idle"}, 64'(rec_zeros(lr + 97, last_cycle)), 64'd0);
        check({tag, " ov_cycle"}, 64'(ov_cycle), 64'(r + 1));
        check({tag, " err"}, 64'(ov_err), 64'(resp[4:0] != 5'b00101));
        check({tag, " data_out"}, ov_data, 64'd0);
        check({tag, " post_busy"}, 64'(post_busy), 64'd0);
    endtask

    initial begin
        logic [63:0] blk;
        logic [7:0]  resp;
        logic [4:0]  lo;
        int          inj;

        bus.in_valid  = 1'b0;
        bus.direction = 1'b0;
        bus.addr      = '0;
        bus.data_in   = '0;
        repeat (3) @(negedge clk);
        check("rst MOSI", 64'(MOSI), 64'd1);
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst out_valid", 64'(bus.out_valid), 64'd0);
        check("rst data_out", bus.data_out, 64'd0);
        check("rst err", 64'(bus.err), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        chk_read("rd0", 16'h0000, 64'h0123_4567_89AB_CDEF, 16'h0000, 2, 3, 0);
        check("rd0 frame_const", rec_bits(1, 48), 64'h51_0000_0000_55);
        chk_write("wr0", 16'h0010, 64'h0, 8'b0000_0101, 2, 3, 40);
        chk_read("rd_badcrc", 16'h1234, 64'h0123_4567_89AB_CDEF, 16'h8000, 1, 1, 0);
        chk_write("wr_badresp", 16'h0020, {$urandom, $urandom}, 8'b0000_1011, 0, 0, 5);
        chk_write("wr_zerobusy", 16'hBEEF, {$urandom, $urandom}, 8'b0000_0101, 5, 0, 0);
        chk_read("rd_inject", 16'h0042, {$urandom, $urandom}, 16'h0000, 4, 4, 20);

        // Reset in the middle of the data phase of a write carrying all-zero data.
        sched_clear();
        sched_put(52, 64'h00, 8);
        run_txn(1'b1, 16'h00AA, 64'h0, 0, 99, 300, 1);
        check("rstwr mosi_before", 64'(mosi_rec[99]), 64'd0);
        check("rstwr MOSI", 64'(rst_mosi), 64'd1);
        check("rstwr busy", 64'(rst_busy), 64'd0);
        check("rstwr out_valid", 64'(rst_ov), 64'd0);
        check("rstwr ov_count", 64'(ov_count), 64'd0);

        sched_clear();
`ifdef SD_HOST_TIMEOUT_EN
        run_txn(1'b0, 16'h0777, 64'h0, 0, 0, 800, 5);
        check("tmo ov_cycle", 64'(ov_cycle), 64'(49 + 64 * UNIT));
        check("tmo err", 64'(ov_err), 64'd1);
        check("tmo data_out", ov_data, 64'd0);
        check("tmo post_busy", 64'(post_busy), 64'd0);
`else
        run_txn(1'b0, 16'h0777, 64'h0, 0, 0, 700, 5);
        check("hang ov_count", 64'(ov_count), 64'd0);
        check("hang busy", 64'(bus.busy), 64'd1);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post_rst busy", 64'(bus.busy), 64'd0);

        for (int t = 0; t < 12; t++) begin
            blk = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                lo = 5'($urandom);
                if ($urandom_range(0, 1) == 1) lo = 5'b00101;
                resp = {1'b0, 2'($urandom), lo};
                chk_write("rnd_wr", 16'($urandom), blk, resp,
                          $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 60));
            end else begin
                inj = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 100) : 0;
                chk_read("rnd_rd", 16'($urandom), blk,
                         ($urandom_range(0, 2) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0,
                         $urandom_range(0, 12), $urandom_range(0, 12), inj);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
